// File: rtl/ql_mac_pipe.sv
// ql_mac_pipe: three-stage pipelined multiply-accumulate for the eFPGA math unit.
// Stage 1 registers the extended product with its per-sample control flags and
// tracks burst position; stage 2 updates the accumulator; stage 3 produces the
// windowed, optionally saturated result for the last sample of each burst.
// Optional build macro QL_MAC_SAT_STICKY_EN: when defined, MAC_SAT_FLAG holds
// once set and clears only on reset or on the result of a burst that began
// with MAC_ACC_CLEAR. When undefined, the flag reflects each result on its own.
module ql_mac_pipe #(
    parameter int MULTI_WIDTH = 8,
    parameter int GUARD_BITS  = 4,
    parameter int ACC_WIDTH   = 2*MULTI_WIDTH+GUARD_BITS,
    parameter int SEL_WIDTH   = 5,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                   MAC_ACC_CLK,
    input  logic                   acc_ff_rstn,
    input  logic                   EFPGA_MATHB_CLK_EN,
    input  logic                   MAC_IN_VALID,
    input  logic [MULTI_WIDTH-1:0] MAC_OPER_DATA,
    input  logic [MULTI_WIDTH-1:0] MAC_COEF_DATA,
    input  logic                   MAC_ACC_CLEAR,
    input  logic                   MAC_ACC_RND,
    input  logic                   MAC_ACC_SAT,
    input  logic [SEL_WIDTH-1:0]   MAC_OUT_SEL,
    input  logic                   MAC_TC,
    input  logic [LEN_WIDTH-1:0]   MAC_ACC_LEN,
    output logic [MULTI_WIDTH-1:0] MAC_OUT,
    output logic                   MAC_OUT_VALID,
    output logic [ACC_WIDTH-1:0]   MAC_ACC_OUT,
    output logic                   MAC_SAT_FLAG
);

    localparam int W    = MULTI_WIDTH;
    localparam int A    = ACC_WIDTH;
    localparam int EXT  = ACC_WIDTH - 2*MULTI_WIDTH;
    localparam int MAXS = ACC_WIDTH - MULTI_WIDTH;

    logic                 accept;

    // burst tracking
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 acl_q;
    logic                 bclr_q;
    logic                 first;
    logic [LEN_WIDTH-1:0] len_eff;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic                 last;
    logic                 bclr_nxt;

    // product
    logic signed [2*W-1:0] prod_s;
    logic [2*W-1:0]        prod_u;
    logic [A-1:0]          prod_ext;

    // stage 1 registers
    logic                 s1_valid;
    logic [A-1:0]         s1_prod;
    logic                 s1_clr;
    logic                 s1_rnd;
    logic                 s1_sat;
    logic                 s1_tc;
    logic [SEL_WIDTH-1:0] s1_sel;
    logic                 s1_last;
    logic                 s1_bclr;

    // stage 2
    logic [A-1:0]         acc;
    logic [A-1:0]         rnd_c;
    logic [A-1:0]         base;
    logic                 s2_valid;
    logic                 s2_sat;
    logic                 s2_tc;
    logic [SEL_WIDTH-1:0] s2_sel;
    logic                 s2_bclr;

    // stage 3
    logic [SEL_WIDTH-1:0]  sel_eff;
    logic [SEL_WIDTH:0]    sh_tc;
    logic [SEL_WIDTH:0]    sh_un;
    logic [A-1:0]          win_full;
    logic signed [A-1:0]   tc_hi;
    logic [A-1:0]          un_hi;
    logic                  tc_ok;
    logic                  un_ok;
    logic                  sat_hit;
    logic [W-1:0]          sat_val;
    logic [W-1:0]          out_nxt;

    assign accept = EFPGA_MATHB_CLK_EN & MAC_IN_VALID;

    // Burst position of the incoming sample; LEN is taken only from a burst's first sample.
    always_comb begin
        first    = (cnt == '0) | MAC_ACC_CLEAR;
        len_eff  = first ? MAC_ACC_LEN : len_q;
        cnt_inc  = MAC_ACC_CLEAR ? LEN_WIDTH'(1) : cnt + LEN_WIDTH'(1);
        last     = (len_eff == '0) | (cnt_inc == len_eff);
        bclr_nxt = MAC_ACC_CLEAR | (~first & bclr_q);
    end

    // Full-width product, sign- or zero-extended into the accumulator width.
    always_comb begin
        prod_s   = $signed({{W{MAC_OPER_DATA[W-1]}}, MAC_OPER_DATA})
                 * $signed({{W{MAC_COEF_DATA[W-1]}}, MAC_COEF_DATA});
        prod_u   = {{W{1'b0}}, MAC_OPER_DATA} * {{W{1'b0}}, MAC_COEF_DATA};
        prod_ext = MAC_TC ? {{EXT{prod_s[2*W-1]}}, prod_s} : {{EXT{1'b0}}, prod_u};
    end

    // Burst counter; a finished finite burst arms an auto-clear for the next sample.
    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            cnt    <= '0;
            len_q  <= '0;
            acl_q  <= 1'b0;
            bclr_q <= 1'b0;
        end else if (accept) begin
            len_q  <= len_eff;
            cnt    <= last ? '0 : cnt_inc;
            acl_q  <= last & (len_eff != '0);
            bclr_q <= bclr_nxt;
        end
    end

    // Stage 1: product and per-sample flags travel together.
    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_clr   <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_sat   <= 1'b0;
            s1_tc    <= 1'b0;
            s1_sel   <= '0;
            s1_last  <= 1'b0;
            s1_bclr  <= 1'b0;
        end else if (EFPGA_MATHB_CLK_EN) begin
            s1_valid <= MAC_IN_VALID;
            if (MAC_IN_VALID) begin
                s1_prod <= prod_ext;
                s1_clr  <= MAC_ACC_CLEAR | acl_q;
                s1_rnd  <= MAC_ACC_RND;
                s1_sat  <= MAC_ACC_SAT;
                s1_tc   <= MAC_TC;
                s1_sel  <= MAC_OUT_SEL;
                s1_last <= last;
                s1_bclr <= bclr_nxt;
            end
        end
    end

    // Accumulator base: clear dominates rounding, which replaces the running sum.
    always_comb begin
        rnd_c = '0;
        if ((s1_sel != '0) && (s1_sel <= SEL_WIDTH'(MAXS)))
            rnd_c = {{(A-1){1'b0}}, 1'b1} << (s1_sel - SEL_WIDTH'(1));
        if (s1_clr)
            base = '0;
        else if (s1_rnd)
            base = rnd_c;
        else
            base = acc;
    end

    // Stage 2: accumulate (wraps modulo 2^A) and forward result controls.
    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            acc      <= '0;
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
            s2_tc    <= 1'b0;
            s2_sel   <= '0;
            s2_bclr  <= 1'b0;
        end else if (EFPGA_MATHB_CLK_EN) begin
            s2_valid <= s1_valid & s1_last;
            if (s1_valid) begin
                acc     <= base + s1_prod;
                s2_sat  <= s1_sat;
                s2_tc   <= s1_tc;
                s2_sel  <= s1_sel;
                s2_bclr <= s1_bclr;
            end
        end
    end

    assign MAC_ACC_OUT = acc;

    // Output window and overflow check; an out-of-range window position falls back to 0.
    always_comb begin
        sel_eff  = (s2_sel > SEL_WIDTH'(MAXS)) ? '0 : s2_sel;
        sh_tc    = {1'b0, sel_eff} + (SEL_WIDTH+1)'(W-1);
        sh_un    = {1'b0, sel_eff} + (SEL_WIDTH+1)'(W);
        win_full = acc >> sel_eff;
        tc_hi    = $signed(acc) >>> sh_tc;
        un_hi    = acc >> sh_un;
        tc_ok    = (tc_hi == '0) | (tc_hi == '1);
        un_ok    = (un_hi == '0);
        sat_hit  = s2_sat & (s2_tc ? ~tc_ok : ~un_ok);
        if (!s2_tc)
            sat_val = '1;
        else if (acc[A-1])
            sat_val = {1'b1, {(W-1){1'b0}}};
        else
            sat_val = {1'b0, {(W-1){1'b1}}};
        out_nxt  = sat_hit ? sat_val : win_full[W-1:0];
    end

    // Stage 3: register the result of a burst's last sample.
    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            MAC_OUT       <= '0;
            MAC_OUT_VALID <= 1'b0;
            MAC_SAT_FLAG  <= 1'b0;
        end else if (EFPGA_MATHB_CLK_EN) begin
            MAC_OUT_VALID <= s2_valid;
            if (s2_valid) begin
                MAC_OUT <= out_nxt;
`ifdef QL_MAC_SAT_STICKY_EN
                MAC_SAT_FLAG <= sat_hit | (MAC_SAT_FLAG & ~s2_bclr);
`else
                MAC_SAT_FLAG <= sat_hit;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ql_mac_pipe.sv
// tb_ql_mac_pipe: directed scenarios plus a randomized stream for ql_mac_pipe,
// checked every cycle against a sample-level arithmetic model.
module tb_ql_mac_pipe;

    localparam int  W    = 8;
    localparam int  A    = 20;
    localparam longint MASK = (longint'(1) << A) - 1;

    logic           clk = 1'b0;
    logic           rst_b;
    logic           en, vld, clr, rnd, sat, tc;
    logic [W-1:0]   oper, coef;
    logic [4:0]     sel;
    logic [7:0]     len;
    logic [W-1:0]   mac_out;
    logic           out_valid;
    logic [A-1:0]   acc_out;
    logic           sat_flag;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;

    // model state
    longint m_acc;
    int     m_cnt, m_len;
    bit     m_acl, m_bclr, m_flag;
    longint exp_acc [int];
    int     exp_out [int];
    bit     exp_flag [int];
    longint cur_acc;
    int     cur_out;
    bit     cur_valid, cur_flag;

    int lens [5] = '{0, 1, 2, 3, 5};

    always #5 clk = ~clk;

    ql_mac_pipe dut (
        .MAC_ACC_CLK        (clk),
        .acc_ff_rstn        (rst_b),
        .EFPGA_MATHB_CLK_EN (en),
        .MAC_IN_VALID       (vld),
        .MAC_OPER_DATA      (oper),
        .MAC_COEF_DATA      (coef),
        .MAC_ACC_CLEAR      (clr),
        .MAC_ACC_RND        (rnd),
        .MAC_ACC_SAT        (sat),
        .MAC_OUT_SEL        (sel),
        .MAC_TC             (tc),
        .MAC_ACC_LEN        (len),
        .MAC_OUT            (mac_out),
        .MAC_OUT_VALID      (out_valid),
        .MAC_ACC_OUT        (acc_out),
        .MAC_SAT_FLAG       (sat_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, expv, edge_n);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_len = 0; m_acl = 0; m_bclr = 0; m_flag = 0;
        exp_acc.delete(); exp_out.delete(); exp_flag.delete();
        cur_acc = 0; cur_out = 0; cur_valid = 0; cur_flag = 0;
    endtask

    // One accepted sample, evaluated from the arithmetic rules.
    task automatic model_accept();
        longint p, base, sval, hi;
        int     so, sc, s, se, win, outv;
        bit     first, last, ok, hit;
        so = (oper >= 128) ? int'(oper) - 256 : int'(oper);
        sc = (coef >= 128) ? int'(coef) - 256 : int'(coef);
        p  = tc ? longint'(so * sc) : longint'(int'(oper) * int'(coef));
        p  = p & MASK;
        s  = int'(sel);
        first = (m_cnt == 0) || clr;
        if (first) m_len = int'(len);
        if (clr || m_acl)
            base = 0;
        else if (rnd)
            base = (s >= 1 && s <= A - W) ? (longint'(1) << (s - 1)) : 0;
        else
            base = m_acc;
        m_acc  = (base + p) & MASK;
        m_bclr = clr ? 1'b1 : (first ? 1'b0 : m_bclr);
        m_cnt  = clr ? 1 : m_cnt + 1;
        last   = (m_len == 0) || (m_cnt == m_len);
        if (last) m_cnt = 0;
        m_acl  = last && (m_len != 0);
        exp_acc[edge_n + 1] = m_acc;
        if (last) begin
            se   = (s > A - W) ? 0 : s;
            win  = int'((m_acc >> se) & 255);
            sval = m_acc[A-1] ? m_acc - (longint'(1) << A) : m_acc;
            if (tc) begin
                hi = sval >>> (se + W - 1);
                ok = (hi == 0) || (hi == -1);
            end else begin
                ok = ((m_acc >> (se + W)) == 0);
            end
            hit  = sat && !ok;
            outv = !hit ? win : (!tc ? 255 : (sval < 0 ? 8'h80 : 8'h7F));
`ifdef QL_MAC_SAT_STICKY_EN
            m_flag = hit || (m_flag && !m_bclr);
`else
            m_flag = hit;
`endif
            exp_out[edge_n + 2]  = outv;
            exp_flag[edge_n + 2] = m_flag;
        end
    endtask

    // One clock; on enabled edges the model schedules and retires expectations.
    task automatic cycle();
        @(posedge clk);
        if (en) begin
            edge_n++;
            if (vld) model_accept();
        end
        #1;
        if (en) begin
            cur_valid = exp_out.exists(edge_n);
            if (cur_valid) begin
                cur_out  = exp_out[edge_n];
                cur_flag = exp_flag[edge_n];
                exp_out.delete(edge_n);
                exp_flag.delete(edge_n);
            end
            if (exp_acc.exists(edge_n)) begin
                cur_acc = exp_acc[edge_n];
                exp_acc.delete(edge_n);
            end
        end
        chk(en ? "out_valid" : "stall_valid", 32'(out_valid), 32'(cur_valid));
        chk(en ? "mac_out"   : "stall_out",   32'(mac_out),   32'(cur_out));
        chk(en ? "sat_flag"  : "stall_flag",  32'(sat_flag),  32'(cur_flag));
        chk(en ? "acc_out"   : "stall_acc",   32'(acc_out),   32'(cur_acc));
    endtask

    task automatic smp(input int o, input int c, input bit t, input int l, input int s,
                       input bit sa, input bit cl, input bit rn);
        en = 1; vld = 1;
        oper = W'(o); coef = W'(c); tc = t; len = 8'(l); sel = 5'(s);
        sat = sa; clr = cl; rnd = rn;
        cycle();
        vld = 0; clr = 0; rnd = 0;
    endtask

    task automatic idle(input int n);
        en = 1; vld = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic async_reset();
        rst_b = 0;
        #1;
        chk("rst_out",   32'(mac_out),   0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_acc",   32'(acc_out),   0);
        chk("rst_flag",  32'(sat_flag),  0);
        model_reset();
        #1;
        rst_b = 1;
    endtask

    initial begin
        rst_b = 0; en = 0; vld = 0; clr = 0; rnd = 0; sat = 0; tc = 0;
        oper = 0; coef = 0; sel = 0; len = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        async_reset();

        // 1: unsigned 3*5, LEN=1
        smp(3, 5, 0, 1, 0, 0, 1, 0);
        idle(3);
        chk("t1_acc", 32'(acc_out), 15);
        chk("t1_out", 32'(mac_out), 8'h0F);

        // 2: TC (-2)*3, LEN=4, then a fifth sample auto-clears
        for (int i = 0; i < 4; i++) smp(8'hFE, 3, 1, 4, 0, 0, (i == 0), 0);
        idle(3);
        chk("t2_acc", 32'(acc_out), 20'hFFFE8);
        chk("t2_out", 32'(mac_out), 8'hE8);
        smp(8'hFE, 3, 1, 4, 0, 0, 0, 0);
        idle(3);
        chk("t2_acc5", 32'(acc_out), 20'hFFFFA);

        // 3: unsigned 255*255 with different windows / saturation
        smp(255, 255, 0, 1, 8, 1, 1, 0);
        idle(3);
        chk("t3a_out", 32'(mac_out), 8'hFE);
        chk("t3a_flag", 32'(sat_flag), 0);
        smp(255, 255, 0, 1, 0, 1, 1, 0);
        idle(3);
        chk("t3b_out", 32'(mac_out), 8'hFF);
        chk("t3b_flag", 32'(sat_flag), 1);
        smp(255, 255, 0, 1, 0, 0, 1, 0);
        idle(3);
        chk("t3c_out", 32'(mac_out), 8'h01);
`ifndef QL_MAC_SAT_STICKY_EN
        chk("t3c_flag", 32'(sat_flag), 0);
`endif

        // 4: TC saturation both directions
        smp(8'h80, 127, 1, 2, 0, 1, 1, 0);
        smp(8'h80, 127, 1, 2, 0, 1, 0, 0);
        idle(3);
        chk("t4_acc", 32'(acc_out), 20'hF8100);
        chk("t4_out", 32'(mac_out), 8'h80);
        chk("t4_flag", 32'(sat_flag), 1);
        smp(127, 127, 1, 2, 0, 1, 1, 0);
        smp(127, 127, 1, 2, 0, 1, 0, 0);
        idle(3);
        chk("t4p_out", 32'(mac_out), 8'h7F);

        // 5: rounding constant, and clear dominating it
        smp(0, 0, 0, 0, 0, 0, 1, 0);
        smp(1, 9, 0, 1, 4, 0, 0, 1);
        idle(3);
        chk("t5_acc", 32'(acc_out), 17);
        chk("t5_out", 32'(mac_out), 8'h01);
        smp(1, 9, 0, 1, 4, 0, 1, 1);
        idle(3);
        chk("t5c_acc", 32'(acc_out), 9);
        chk("t5c_out", 32'(mac_out), 8'h00);

        // 6a: stall mid-burst
        smp(10, 10, 0, 3, 0, 0, 1, 0);
        smp(10, 10, 0, 3, 0, 0, 0, 0);
        en = 0; vld = 1;
        for (int i = 0; i < 5; i++) cycle();
        smp(10, 10, 0, 3, 0, 0, 0, 0);
        idle(3);
        chk("t6_acc", 32'(acc_out), 300);
        chk("t6_out", 32'(mac_out), 8'h2C);

        // 6b: reset mid-burst, next burst counts from sample 1
        smp(2, 2, 0, 3, 0, 0, 1, 0);
        smp(2, 2, 0, 3, 0, 0, 0, 0);
        async_reset();
        for (int i = 0; i < 3; i++) smp(1, 1, 0, 3, 0, 0, 0, 0);
        idle(3);
        chk("t6r_acc", 32'(acc_out), 3);
        chk("t6r_out", 32'(mac_out), 3);

`ifdef QL_MAC_SAT_STICKY_EN
        // 6c: sticky flag survives a non-saturating burst until a CLEAR burst
        smp(255, 255, 0, 1, 0, 1, 1, 0);
        idle(3);
        chk("stk_set", 32'(sat_flag), 1);
        smp(1, 1, 0, 1, 0, 1, 0, 0);
        idle(3);
        chk("stk_hold", 32'(sat_flag), 1);
        smp(1, 1, 0, 1, 0, 1, 1, 0);
        idle(3);
        chk("stk_clr", 32'(sat_flag), 0);
`endif

        // randomized stream
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            vld  = ($urandom_range(0, 3) != 0);
            oper = W'($urandom);
            coef = W'($urandom);
            clr  = ($urandom_range(0, 9) == 0);
            rnd  = ($urandom_range(0, 7) == 0);
            sat  = 1'($urandom);
            tc   = 1'($urandom);
            sel  = 5'($urandom_range(0, 15));
            len  = 8'(lens[$urandom_range(0, 4)]);
            cycle();
        end
        idle(4);
        chk("drain", 32'(exp_out.num()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ql_mac_pipe.md
Name: ql_mac_pipe

Overview:
Parametrised, pipelined successor to the 4-bit eFPGA math-block MAC. It supports:
- configurable operand and accumulator widths;
- a valid-qualified input stream;
- burst accumulation with automatic dump and clear after a programmable sample count;
- registered, windowed, optionally saturated output.

It sits in the eFPGA math unit between fabric operand routing and fabric result capture.

Parameters:
MULTI_WIDTH, 8, operand width W for OPER and COEF, and width of MAC_OUT.
GUARD_BITS, 4, accumulator guard bits.
ACC_WIDTH, 2*MULTI_WIDTH+GUARD_BITS, accumulator width A.
SEL_WIDTH, 5, width of MAC_OUT_SEL; must satisfy 2^SEL_WIDTH > A-W.
LEN_WIDTH, 8, width of MAC_ACC_LEN.

Ports:
MAC_ACC_CLK  input  1  clock, rising edge.
acc_ff_rstn  input  1  asynchronous, active-low reset.
EFPGA_MATHB_CLK_EN  input  1  pipeline advance enable; low = full stall.
MAC_IN_VALID  input  1  operand sample valid.
MAC_OPER_DATA  input  W  operand.
MAC_COEF_DATA  input  W  coefficient.
MAC_ACC_CLEAR  input  1  this sample replaces the accumulator.
MAC_ACC_RND  input  1  this sample is added to the rounding constant instead of the accumulator.
MAC_ACC_SAT  input  1  enable output saturation.
MAC_OUT_SEL  input  SEL_WIDTH  output window LSB position s.
MAC_TC  input  1  1 = two's complement, 0 = unsigned.
MAC_ACC_LEN  input  LEN_WIDTH  samples per burst; 0 = continuous.
MAC_OUT  output  W  windowed, saturated result.
MAC_OUT_VALID  output  1  MAC_OUT holds a new result.
MAC_ACC_OUT  output  A  raw accumulator value.
MAC_SAT_FLAG  output  1  saturation indicator.

Behaviour:
- Reset (asynchronous): all pipeline registers, accumulator, burst counter, MAC_OUT, MAC_OUT_VALID, MAC_ACC_OUT and MAC_SAT_FLAG go to 0. Reset mid-burst discards the burst; the next sample is burst sample 1.
- Accept: a sample is accepted on a rising edge with MAC_IN_VALID=1 and EFPGA_MATHB_CLK_EN=1. With EFPGA_MATHB_CLK_EN=0 no register changes, outputs hold, and MAC_IN_VALID is ignored.
- Stage 1 (accept edge T):
  - product P = OPER*COEF, 2W bits, signed if MAC_TC else unsigned;
  - P is sign- or zero-extended to A bits;
  - CLEAR, RND, SAT, TC and s are registered with P, so each sample's flags stay aligned with its data.
- Stage 2 (edge T+1):
  - base = 0 if CLEAR or auto-clear; else rounding constant if RND; else acc. CLEAR dominates RND.
  - acc <= base + P, modulo 2^A.
  - MAC_ACC_OUT = acc.
- Rounding constant: 1<<(s-1) for 1<=s<=A-W; 0 for s=0 or s>A-W.
- Burst counter:
  - MAC_ACC_LEN is latched on the first sample of each burst (counter=0, or CLEAR).
  - CLEAR restarts the count at 1.
  - When the counter reaches LEN, the sample is marked "last"; the counter returns to 0 and the following sample auto-clears.
  - LEN=0: every sample is "last" and there is no auto-clear (continuous mode).
- Stage 3 (edge T+2), only for a "last" sample:
  - MAC_OUT = window acc[s+W-1:s]; s>A-W is treated as s=0;
  - MAC_OUT_VALID <= 1; otherwise MAC_OUT_VALID <= 0 on any advancing edge.
  - Input-to-output latency is 3 enabled edges. Throughput is 1 sample per enabled cycle, with back-to-back bursts and no bubble.
- Saturation check:
  - TC: bits acc[A-1:s+W-1] are all equal.
  - Unsigned: acc[A-1:s+W] is all 0.
  - If MAC_ACC_SAT=1 and the check fails, MAC_OUT = all-ones (unsigned), or 1 followed by 0s if acc[A-1]=1 (TC), or 0 followed by 1s (TC, positive).
  - MAC_SAT_FLAG is registered with MAC_OUT: 1 when saturation was applied.
  - MAC_ACC_SAT=0: MAC_OUT is the raw window and the flag is 0.
- Accumulator overflow beyond A bits wraps silently.

Optional Feature:
QL_MAC_SAT_STICKY_EN
- Defined: MAC_SAT_FLAG is sticky. It sets on any saturated output and clears only on reset or on the stage-3 result of a burst started with MAC_ACC_CLEAR.
- Undefined: MAC_SAT_FLAG is per-result as described in Behaviour.

Test Plan:
All scenarios use W=8, A=20.
1. Unsigned, LEN=1, s=0, OPER=3, COEF=5 -> 3 enabled edges later: MAC_OUT=0x0F, MAC_OUT_VALID 1-cycle pulse, MAC_ACC_OUT=15.
2. TC, LEN=4, OPER=0xFE (-2), COEF=3, four consecutive samples -> single valid pulse, MAC_ACC_OUT=0xFFFE8, MAC_OUT=0xE8; a fifth sample starts a fresh accumulation, giving acc=0xFFFFA.
3. Unsigned 255*255, LEN=1:
   - s=8, SAT=1 -> MAC_OUT=0xFE, flag 0;
   - s=0, SAT=1 -> 0xFF, flag 1;
   - s=0, SAT=0 -> 0x01.
4. TC, LEN=2, two samples of -128*127, s=0, SAT=1 -> acc=-32512, MAC_OUT=0x80, flag 1; repeat with 127*127 twice -> 0x7F.
5. RND=1, s=4, OPER=1, COEF=9, LEN=1 -> acc=17, MAC_OUT=0x01; the same sample with CLEAR=1 as well -> acc=9, MAC_OUT=0x00.
6. Stall and reset:
   - EFPGA_MATHB_CLK_EN low for 5 cycles mid-burst -> all outputs frozen, result identical to the unstalled run;
   - acc_ff_rstn pulse mid-burst -> all outputs 0 immediately, next burst counts from 1;
   - sticky build -> flag persists across a non-saturating burst until a CLEAR burst completes.
